// File: rtl/uart_pkg.sv
// uart_pkg - shared types and constants for the parametrised UART transmitter.
//   tx_state_t   : frame sequencer state encoding
//   LINE_IDLE    : serial line level when nothing is being sent (mark)
//   START_LVL    : serial line level of the start bit (space)
//   frame_cfg_t  : per-frame format captured on accept
// The prescale field is sized for the widest supported PRESCALE input;
// narrower inputs are zero-extended into it.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    localparam int CFG_PRESCALE_W = 16;

    typedef struct packed {
        logic                      par_en;
        logic                      par_typ;
        logic                      stop2;
        logic [CFG_PRESCALE_W-1:0] prescale;
    } frame_cfg_t;

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if - word handshake plus per-frame format between the
// register/bus side (master) and the UART transmitter (slave).
//   P_DATA     word to transmit
//   DATA_VALID P_DATA and format fields are valid
//   DATA_READY transmitter takes the word at the next rising edge
//   PAR_EN     1 = insert parity bit
//   PAR_TYP    0 = even, 1 = odd
//   STOP2      1 = two stop bits
//   PRESCALE   clocks per bit minus one
interface uart_tx_param_if #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 8
);
    logic [DATA_W-1:0]     P_DATA;
    logic                  DATA_VALID;
    logic                  DATA_READY;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [PRESCALE_W-1:0] PRESCALE;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, PRESCALE,
        input  DATA_READY
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, PRESCALE,
        output DATA_READY
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo - generic synchronous FIFO, show-ahead read.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (pointers only)
//   push     write wr_data (ignored when full)
//   wr_data  entry to store
//   full     no free entry
//   pop      drop the head entry (ignored when empty)
//   rd_data  current head entry
//   empty    no stored entry
// DEPTH must be a power of two; pointers carry one extra wrap bit so that
// equal indices can be told apart as full or empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param - parametrised UART transmitter with valid/ready word input.
//   CLK      system clock, rising edge
//   RST      asynchronous active-low reset
//   bus      uart_tx_param_if.slave: P_DATA/DATA_VALID/DATA_READY plus
//            PAR_EN, PAR_TYP, STOP2, PRESCALE format fields
//   TX_OUT   serial line, idle high, driven from a flop
//   BUSY     frame in progress (START..STOP)
//   TX_DONE  one-cycle pulse in the last cycle of the final stop bit
// Build option: define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in
// front of the frame sequencer; otherwise words are taken directly.
//
// state  | meaning
// IDLE   | line high, waiting for a word
// START  | start bit (line low)
// DATA   | data bits, LSB first, bit_idx 0..DATA_W-1
// PARITY | parity bit, only when par_en was latched
// STOP   | one or two stop bits (line high)
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    uart_tx_param_if.slave  bus,
    output logic            TX_OUT,
    output logic            BUSY,
    output logic            TX_DONE
);
    localparam int BIT_IDX_W = $clog2(DATA_W);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(DATA_W - 1);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_param: DATA_W must be within 5..9");
    end
    if (PRESCALE_W < 1 || PRESCALE_W > CFG_PRESCALE_W) begin : g_bad_prescale_w
        $error("uart_tx_param: PRESCALE_W out of range");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_t                 state;
    logic [CFG_PRESCALE_W-1:0] baud_cnt;
    logic [BIT_IDX_W-1:0]      bit_idx;
    logic [BIT_IDX_W-1:0]      bit_nxt;
    logic                      stop_cnt;
    logic [DATA_W-1:0]         data_reg;
    frame_cfg_t                cfg;
    logic                      tx_reg;

    frame_cfg_t        in_cfg;
    frame_cfg_t        src_cfg;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              ready;
    logic              baud_tc;
    logic              last_stop;
    logic              can_take;
    logic              take;

    always_comb begin
        in_cfg.par_en   = bus.PAR_EN;
        in_cfg.par_typ  = bus.PAR_TYP;
        in_cfg.stop2    = bus.STOP2;
        in_cfg.prescale = CFG_PRESCALE_W'(bus.PRESCALE);
    end

    assign baud_tc   = (baud_cnt == cfg.prescale);
    assign last_stop = (state == STOP) && baud_tc && (stop_cnt == cfg.stop2);
    // A new frame can start in IDLE or in the final stop cycle, which is what
    // makes back-to-back frames gapless.
    assign can_take  = (state == IDLE) || last_stop;
    assign take      = src_valid && can_take;
    assign bit_nxt   = bit_idx + 1'b1;

`ifdef UART_TX_FIFO_EN
    localparam int ENTRY_W = DATA_W + $bits(frame_cfg_t);

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_rd;

    assign ready     = RST && !fifo_full;
    assign fifo_push = bus.DATA_VALID && ready;
    assign fifo_pop  = can_take && !fifo_empty;
    assign src_valid = !fifo_empty;
    assign {src_cfg, src_data} = fifo_rd;

    uart_tx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .push    (fifo_push),
        .wr_data ({in_cfg, bus.P_DATA}),
        .full    (fifo_full),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .empty   (fifo_empty)
    );
`else
    // RST gating keeps READY low while reset is held even though the
    // sequencer already sits in IDLE.
    assign ready     = RST && can_take;
    assign src_valid = bus.DATA_VALID;
    assign src_cfg   = in_cfg;
    assign src_data  = bus.P_DATA;
`endif

    assign bus.DATA_READY = ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            data_reg <= '0;
            cfg      <= '0;
            tx_reg   <= LINE_IDLE;
        end else begin
            baud_cnt <= (state == IDLE || baud_tc) ? '0 : baud_cnt + 1'b1;

            case (state)
                IDLE: begin
                    tx_reg <= LINE_IDLE;
                end
                START: begin
                    if (baud_tc) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx_reg  <= data_reg[0];
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        if (bit_idx == BIT_LAST) begin
                            if (cfg.par_en) begin
                                state  <= PARITY;
                                tx_reg <= cfg.par_typ ? ~^data_reg : ^data_reg;
                            end else begin
                                state    <= STOP;
                                stop_cnt <= 1'b0;
                                tx_reg   <= LINE_IDLE;
                            end
                        end else begin
                            bit_idx <= bit_nxt;
                            tx_reg  <= data_reg[bit_nxt];
                        end
                    end
                end
                PARITY: begin
                    if (baud_tc) begin
                        state    <= STOP;
                        stop_cnt <= 1'b0;
                        tx_reg   <= LINE_IDLE;
                    end
                end
                STOP: begin
                    if (last_stop) begin
                        state  <= IDLE;
                        tx_reg <= LINE_IDLE;
                    end else if (baud_tc) begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_reg <= LINE_IDLE;
                end
            endcase

            // Accept overrides the per-state update so the next START bit
            // follows the final stop cycle directly.
            if (take) begin
                state    <= START;
                baud_cnt <= '0;
                data_reg <= src_data;
                cfg      <= src_cfg;
                tx_reg   <= START_LVL;
            end
        end
    end

    assign TX_OUT  = tx_reg;
    assign BUSY    = (state != IDLE);
    assign TX_DONE = last_stop;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param - self-checking bench for uart_tx_param. A driver pushes
// the expected frame onto a scoreboard queue at each accepted word; a line
// monitor pops it when a start bit appears and checks every bit period.
module tb_uart_tx_param;
    localparam int DATA_W     = 8;
    localparam int PRESCALE_W = 8;
`ifdef UART_TX_FIFO_EN
    localparam int FIFO_LAT = 1;
`else
    localparam int FIFO_LAT = 0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic TX_OUT;
    logic BUSY;
    logic TX_DONE;

    uart_tx_param_if #(.DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W)) bus ();

    uart_tx_param #(
        .DATA_W     (DATA_W),
        .PRESCALE_W (PRESCALE_W),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus),
        .TX_OUT  (TX_OUT),
        .BUSY    (BUSY),
        .TX_DONE (TX_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DATA_W-1:0]     data;
        logic                  par_en;
        logic                  par_typ;
        logic                  stop2;
        logic [PRESCALE_W-1:0] prescale;
    } exp_t;

    exp_t        sb_q[$];
    int          n_total = 0;
    int          n_bad = 0;
    int          frames_done = 0;
    logic [15:0] last_bits = '0;
    int          last_nb = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic check_frame();
        exp_t        e;
        logic [15:0] bits;
        logic [15:0] obs;
        int          idx;
        int          nb;
        int          p;
        bit          aborted;
        if (sb_q.size() == 0) begin
            check_val("unexpected_frame", sb_q.size(), 1);
            for (int k = 0; k < 300 && RST && TX_OUT == 1'b0; k++) @(negedge CLK);
            return;
        end
        e    = sb_q.pop_front();
        bits = '0;
        idx  = 1;
        for (int i = 0; i < DATA_W; i++) begin
            bits[idx] = e.data[i];
            idx++;
        end
        if (e.par_en) begin
            bits[idx] = e.par_typ ? ~^e.data : ^e.data;
            idx++;
        end
        bits[idx] = 1'b1;
        idx++;
        if (e.stop2) begin
            bits[idx] = 1'b1;
            idx++;
        end
        nb      = idx;
        p       = int'(e.prescale) + 1;
        obs     = '0;
        aborted = 1'b0;
        for (int b = 0; b < nb && !aborted; b++) begin
            for (int c = 0; c < p; c++) begin
                if (b != 0 || c != 0) @(negedge CLK);
                if (!RST) begin
                    aborted = 1'b1;
                    break;
                end
                if (c == 0) begin
                    obs[b] = TX_OUT;
                    check_val($sformatf("bit%0d_first", b), TX_OUT, bits[b]);
                    check_val("busy_in_frame", BUSY, 1);
                end else if (c == p - 1) begin
                    check_val($sformatf("bit%0d_last", b), TX_OUT, bits[b]);
                end
                if (b == nb - 1 && c == p - 1) check_val("tx_done_pulse", TX_DONE, 1);
                else if (c == 0) check_val("tx_done_quiet", TX_DONE, 0);
            end
        end
        if (!aborted) begin
            last_bits = obs;
            last_nb   = nb;
            frames_done++;
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (RST && TX_OUT == 1'b0) check_frame();
        end
    end

    task automatic send(input logic [DATA_W-1:0] d, input logic pe, input logic pt,
                        input logic s2, input logic [PRESCALE_W-1:0] ps);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        @(negedge CLK);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.STOP2      = s2;
        bus.PRESCALE   = ps;
        bus.DATA_VALID = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (bus.DATA_READY) begin
                e.data     = d;
                e.par_en   = pe;
                e.par_typ  = pt;
                e.stop2    = s2;
                e.prescale = ps;
                sb_q.push_back(e);
                @(posedge CLK);
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) begin
            check_val("send_accept", bus.DATA_READY, 1);
            bus.DATA_VALID = 1'b0;
        end
    endtask

    task automatic drop_valid();
        @(negedge CLK);
        bus.DATA_VALID = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int k;
        k = 0;
        while (frames_done < target && k < 20000) begin
            @(negedge CLK);
            k++;
        end
        check_val("frames_seen", frames_done, target);
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int busy_n;
        int d;
        int gaps;
        int rbad;
        bit started;

        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.STOP2      = 1'b0;
        bus.PRESCALE   = '0;

        repeat (3) @(negedge CLK);
        check_val("rst_tx_out", TX_OUT, 1);
        check_val("rst_busy", BUSY, 0);
        check_val("rst_tx_done", TX_DONE, 0);
        check_val("rst_ready", bus.DATA_READY, 0);
        RST = 1'b1;
        @(negedge CLK);
        check_val("idle_tx_out", TX_OUT, 1);

        // A5, 4 clocks per bit, 8N1
        send(8'hA5, 1'b0, 1'b0, 1'b0, 8'd3);
        n      = 0;
        busy_n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            n++;
            if (n == 1) bus.DATA_VALID = 1'b0;
            if (BUSY) busy_n++;
            if (TX_DONE) break;
        end
        check_val("t1_done_cycle", n, 40 + FIFO_LAT);
        check_val("t1_busy_cycles", busy_n, 40);
        wait_frames(1);
        check_val("t1_line_bits", last_bits, 16'h034A);
        check_val("t1_frame_len", last_nb, 10);
        @(negedge CLK);
        check_val("t1_idle_busy", BUSY, 0);
        check_val("t1_idle_tx", TX_OUT, 1);

        // parity and two stop bits
        send(8'h07, 1'b1, 1'b0, 1'b0, 8'd1);
        drop_valid();
        wait_frames(2);
        check_val("t2_even_par", last_bits[9], 1);
        check_val("t2_even_len", last_nb, 11);
        send(8'h07, 1'b1, 1'b1, 1'b0, 8'd1);
        drop_valid();
        wait_frames(3);
        check_val("t2_odd_par", last_bits[9], 0);
        send(8'h5A, 1'b0, 1'b0, 1'b1, 8'd2);
        drop_valid();
        wait_frames(4);
        check_val("t2_stop2_len", last_nb, 11);
        check_val("t2_stop2_bits", last_bits[10:9], 2'b11);

        // format inputs changed right after accept must not touch the frame
        send(8'hC6, 1'b0, 1'b0, 1'b0, 8'd3);
        @(negedge CLK);
        bus.DATA_VALID = 1'b0;
        bus.PRESCALE   = 8'd1;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b1;
        bus.STOP2      = 1'b1;
        bus.P_DATA     = 8'hFF;
        wait_frames(5);
        check_val("t4_old_len", last_nb, 10);
        send(8'h39, 1'b1, 1'b1, 1'b1, 8'd1);
        drop_valid();
        wait_frames(6);
        check_val("t4_new_len", last_nb, 12);
        check_val("t4_new_par", last_bits[9], 1);

        // three words with VALID held, one clock per bit
        d       = 0;
        gaps    = 0;
        rbad    = 0;
        started = 1'b0;
        fork
            begin
                send(8'h01, 1'b0, 1'b0, 1'b0, 8'd0);
                send(8'h02, 1'b0, 1'b0, 1'b0, 8'd0);
                send(8'h03, 1'b0, 1'b0, 1'b0, 8'd0);
                drop_valid();
            end
            begin
                for (int k = 0; k < 400 && d < 3; k++) begin
                    @(negedge CLK);
                    if (started && !BUSY) gaps++;
                    if (BUSY) started = 1'b1;
`ifndef UART_TX_FIFO_EN
                    if (bus.DATA_READY != (!BUSY || TX_DONE)) rbad++;
`endif
                    if (TX_DONE) d++;
                end
            end
        join
        check_val("t3_done_pulses", d, 3);
        check_val("t3_idle_gaps", gaps, 0);
`ifndef UART_TX_FIFO_EN
        check_val("t3_ready_windows", rbad, 0);
`endif
        wait_frames(9);

        // reset in the middle of data bit 0 (line low)
        send(8'h3C, 1'b0, 1'b0, 1'b0, 8'd3);
        drop_valid();
        repeat (5) @(negedge CLK);
        check_val("t5_pre_rst_tx", TX_OUT, 0);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check_val("t5_rst_tx_out", TX_OUT, 1);
        check_val("t5_rst_busy", BUSY, 0);
        check_val("t5_rst_ready", bus.DATA_READY, 0);
        check_val("t5_rst_done", TX_DONE, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        send(8'hC3, 1'b1, 1'b0, 1'b1, 8'd2);
        drop_valid();
        wait_frames(10);
        check_val("t5_after_len", last_nb, 12);
        check_val("t5_after_par", last_bits[9], 0);

`ifdef UART_TX_FIFO_EN
        // five words into a four-entry FIFO at 8 clocks per bit
        for (int i = 0; i < 5; i++) begin
            send(8'(16 + i), 1'b0, 1'b0, 1'b0, 8'd7);
        end
        @(negedge CLK);
        check_val("t6_ready_full", bus.DATA_READY, 0);
        bus.DATA_VALID = 1'b0;
        wait_frames(15);
`endif

        check_val("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
